// File: rtl/rca_serial_adder.sv
// Multi-cycle ripple-carry adder: SLICE bits per clock, registered carry between slices.
// Optional build macro ADDER_SUB_EN adds a 'sub' input for A - B (A + ~B + 1).
module rca_serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   Sum,
    output logic             busy
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum_q, sum_d;

    logic             accept;
    logic             b_inv;
    logic             cin_eff;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   slice_res;

`ifdef ADDER_SUB_EN
    // Subtract: store ~B and force the initial carry, so A + ~B + 1.
    assign b_inv   = sub;
    assign cin_eff = sub | Cin;
`else
    assign b_inv   = 1'b0;
    assign cin_eff = Cin;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        psum_d   = psum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;

        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;

        a_sl      = a_q[int'(cnt_q) * SLICE +: SLICE];
        b_sl      = b_q[int'(cnt_q) * SLICE +: SLICE];
        slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};

        unique case (state_q)
            IDLE: begin
            end
            RUN: begin
                psum_d[int'(cnt_q) * SLICE +: SLICE] = slice_res[SLICE-1:0];
                carry_d = slice_res[SLICE];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = {slice_res[SLICE], psum_d};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides DONE retirement so a new operation starts without a bubble.
        if (accept) begin
            a_d     = A;
            b_d     = B ^ {WIDTH{b_inv}};
            carry_d = cin_eff;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign Sum       = sum_q;

endmodule

// File: tb/tb_rca_serial_adder.sv
// Directed bench for rca_serial_adder: handshake, stall, back-to-back, reset abort and
// per-SLICE random sums against A+B+Cin.
module tb_rca_serial_adder;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] sum;
    logic       busy;

    // Shared-input group across SLICE = 1, 2, 4, 8.
    logic       r_valid;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_cin;
    logic       r_sub;
    logic       r_ir  [4];
    logic       r_ov  [4];
    logic       r_busy[4];
    logic [8:0] r_sum [4];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rca_serial_adder #(.WIDTH(8), .SLICE(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Cin(cin),
`ifdef ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .Sum(sum), .busy(busy)
    );

    rca_serial_adder #(.WIDTH(8), .SLICE(1)) dut_s1 (
        .clk(clk), .reset(reset), .in_valid(r_valid), .in_ready(r_ir[0]),
        .A(r_a), .B(r_b), .Cin(r_cin),
`ifdef ADDER_SUB_EN
        .sub(r_sub),
`endif
        .out_valid(r_ov[0]), .out_ready(1'b1), .Sum(r_sum[0]), .busy(r_busy[0])
    );

    rca_serial_adder #(.WIDTH(8), .SLICE(2)) dut_s2 (
        .clk(clk), .reset(reset), .in_valid(r_valid), .in_ready(r_ir[1]),
        .A(r_a), .B(r_b), .Cin(r_cin),
`ifdef ADDER_SUB_EN
        .sub(r_sub),
`endif
        .out_valid(r_ov[1]), .out_ready(1'b1), .Sum(r_sum[1]), .busy(r_busy[1])
    );

    rca_serial_adder #(.WIDTH(8), .SLICE(4)) dut_s4 (
        .clk(clk), .reset(reset), .in_valid(r_valid), .in_ready(r_ir[2]),
        .A(r_a), .B(r_b), .Cin(r_cin),
`ifdef ADDER_SUB_EN
        .sub(r_sub),
`endif
        .out_valid(r_ov[2]), .out_ready(1'b1), .Sum(r_sum[2]), .busy(r_busy[2])
    );

    rca_serial_adder #(.WIDTH(8), .SLICE(8)) dut_s8 (
        .clk(clk), .reset(reset), .in_valid(r_valid), .in_ready(r_ir[3]),
        .A(r_a), .B(r_b), .Cin(r_cin),
`ifdef ADDER_SUB_EN
        .sub(r_sub),
`endif
        .out_valid(r_ov[3]), .out_ready(1'b1), .Sum(r_sum[3]), .busy(r_busy[3])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (sum !== 9'h000) $display("FAIL reset_sum got %h want 000", sum); else passed++;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready got %b want 0", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL basic_latency got %b want 1", out_valid); else passed++;
        total++; if (sum !== 9'h100) $display("FAIL basic_sum got %h want 100", sum); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL basic_retire got %b want 0", out_valid); else passed++;
        total++; if (sum !== 9'h100) $display("FAIL basic_sum_kept got %h want 100", sum); else passed++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        a = 8'h7F; b = 8'h80; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0;  // must not disturb the running sum
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", i, out_valid); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); else passed++;
            total++; if (sum !== 9'h100) $display("FAIL stall_sum[%0d] got %h want 100", i, sum); else passed++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready got %b want 1", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL stall_retire got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vc [3];
        logic [8:0] ve [3];
        int         n;
        va[0] = 8'h01; vb[0] = 8'h02; vc[0] = 1'b0; ve[0] = 9'h003;
        va[1] = 8'h10; vb[1] = 8'h20; vc[1] = 1'b1; ve[1] = 9'h031;
        va[2] = 8'hFF; vb[2] = 8'hFF; vc[2] = 1'b1; ve[2] = 9'h1FF;
        out_ready = 1'b1;
        a = va[0]; b = vb[0]; cin = vc[0]; in_valid = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) begin
                a = va[i]; b = vb[i]; cin = vc[i];
            end else begin
                in_valid = 1'b0;
            end
            n = 0;
            while (!out_valid && n < 10) begin
                tick();
                n++;
            end
            total++; if (out_valid !== 1'b1) $display("FAIL b2b_timeout[%0d] got %b want 1", i - 1, out_valid); else passed++;
            total++; if (n != 2) $display("FAIL b2b_spacing[%0d] got %0d want 2", i - 1, n); else passed++;
            total++; if (sum !== ve[i-1]) $display("FAIL b2b_sum[%0d] got %h want %h", i - 1, sum, ve[i-1]); else passed++;
            tick();
        end
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_idle_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_reset_abort();
        int n;
        out_ready = 1'b1;
        a = 8'hAA; b = 8'h00; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL abort_valid got %b want 0", out_valid); else passed++;
        total++; if (sum !== 9'h000) $display("FAIL abort_sum got %h want 000", sum); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got %b want 1", in_ready); else passed++;
        tick();
        reset = 1'b0;
        tick();
        a = 8'h01; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        total++; if (out_valid !== 1'b1) $display("FAIL abort_after_valid got %b want 1", out_valid); else passed++;
        total++; if (sum !== 9'h002) $display("FAIL abort_after_sum got %h want 002", sum); else passed++;
        tick();
    endtask

`ifdef ADDER_SUB_EN
    task automatic test_sub();
        logic [7:0] sa [2];
        logic [7:0] sb [2];
        logic [8:0] se [2];
        int         n;
        sa[0] = 8'h05; sb[0] = 8'h07; se[0] = 9'h0FE;
        sa[1] = 8'h07; sb[1] = 8'h05; se[1] = 9'h102;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = sa[i]; b = sb[i]; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
            tick();
            in_valid = 1'b0; sub = 1'b0;
            n = 0;
            while (!out_valid && n < 10) begin
                tick();
                n++;
            end
            total++; if (sum !== se[i] || out_valid !== 1'b1) $display("FAIL sub_sum[%0d] got %h want %h", i, sum, se[i]); else passed++;
            tick();
        end
    endtask
`endif

    task automatic test_random();
        logic [8:0] exp_sum;
        logic       got [4];
        int         cycles;
        for (int v = 0; v < 200; v++) begin
            r_a = 8'($urandom);
            r_b = 8'($urandom);
            r_cin = 1'($urandom_range(0, 1));
            exp_sum = {1'b0, r_a} + {1'b0, r_b} + {8'h00, r_cin};
            r_valid = 1'b1;
            tick();
            r_valid = 1'b0;
            for (int j = 0; j < 4; j++) got[j] = 1'b0;
            cycles = 0;
            while (cycles < 20 && !(got[0] && got[1] && got[2] && got[3])) begin
                for (int j = 0; j < 4; j++) begin
                    if (!got[j] && r_ov[j]) begin
                        got[j] = 1'b1;
                        total++;
                        if (r_sum[j] !== exp_sum)
                            $display("FAIL rand[%0d] slice_idx %0d A=%h B=%h Cin=%b got %h want %h",
                                     v, j, r_a, r_b, r_cin, r_sum[j], exp_sum);
                        else passed++;
                    end
                end
                tick();
                cycles++;
            end
            for (int j = 0; j < 4; j++) begin
                if (!got[j]) begin
                    total++;
                    $display("FAIL rand_timeout[%0d] slice_idx %0d got no result want one", v, j);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        r_valid = 1'b0; r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_abort();
`ifdef ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
